// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and types for the instruction-memory loader
//               and the processor control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

   // Opcode field occupies instruction bits [10:8]
   localparam logic [2:0] OP_REG    = 3'b000;
   localparam logic [2:0] OP_IMM    = 3'b001;
   localparam logic [2:0] OP_LOAD   = 3'b010;
   localparam logic [2:0] OP_STORE  = 3'b011;
   localparam logic [2:0] OP_BRANCH = 3'b100;
   localparam logic [2:0] OP_JUMP   = 3'b101;
   localparam logic [2:0] OP_INITRD = 3'b110;
   localparam logic [2:0] OP_NOP    = 3'b111;

   // Opcode 111 with a zero payload decodes with no register or memory writes
   localparam logic [10:0] NOP_INSTR = {OP_NOP, 8'h00};

   typedef enum logic [1:0] {
      LOAD_LO = 2'd0,
      LOAD_HI = 2'd1,
      RUN     = 2'd2
   } ld_state_e;

   // Only bits [2:0] of a high byte carry instruction data
   function automatic logic hi_byte_bad(input logic [7:0] b);
      return |b[7:3];
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH x INSTR_W storage, one synchronous write port and a
//               combinational fetch read port. A second combinational read
//               port is added when IMEM_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 11
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
`ifdef IMEM_READBACK_EN
   input  logic [ADDR_W-1:0]  rb_addr_i,
   output logic [INSTR_W-1:0] rb_data_o,
`endif
   output logic [INSTR_W-1:0] rdata_o
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   // Write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

`ifdef IMEM_READBACK_EN
   if (1) begin : g_readback
      assign rb_data_o = mem_q[rb_addr_i];
   end
`endif

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Instruction-memory responder for the 11-bit processor. Loads
//               itself from a byte-serial valid/ready stream (two bytes per
//               word, low byte first), holds the core in reset while loading
//               and serves combinational fetches once the program is complete.
//               Optional macro IMEM_READBACK_EN adds an unmasked host
//               readback port (rb_addr / rb_data).
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  PC,
   output logic [INSTR_W-1:0] Instr,
   output logic               cpu_reset,
   input  logic               ld_valid,
   input  logic [7:0]         ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   input  logic               ld_start,
   output logic               ld_err,
`ifdef IMEM_READBACK_EN
   input  logic [ADDR_W-1:0]  rb_addr,
   output logic [INSTR_W-1:0] rb_data,
`endif
   output logic [ADDR_W:0]    word_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ld_state_e          state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W:0]    word_cnt_q;
   logic [7:0]         lo_byte_q;
   logic               ld_err_q;
   logic               cpu_reset_q;
   logic               ld_ready_q;

   logic               w_accept;
   logic               w_mem_we;
   logic [INSTR_W-1:0] w_mem_wdata;
   logic [INSTR_W-1:0] w_rdata;
   logic               w_pc_valid;

   assign w_accept    = ld_valid & ld_ready_q;
   // A restart wins over a byte offered in the same cycle
   assign w_mem_we    = w_accept & ~ld_start & (state_q == LOAD_HI);
   assign w_mem_wdata = INSTR_W'({ld_data[2:0], lo_byte_q});
   assign w_pc_valid  = ({1'b0, PC} < word_cnt_q);

   imem_array #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_array (
      .clk       (clk),
      .we_i      (w_mem_we),
      .waddr_i   (addr_q),
      .wdata_i   (w_mem_wdata),
      .raddr_i   (PC),
`ifdef IMEM_READBACK_EN
      .rb_addr_i (rb_addr),
      .rb_data_o (rb_data),
`endif
      .rdata_o   (w_rdata)
   );

   // Loader FSM: byte assembly, address/count tracking, error and core reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD_LO;
         addr_q      <= '0;
         word_cnt_q  <= '0;
         lo_byte_q   <= '0;
         ld_err_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         ld_ready_q  <= 1'b1;
      end else if (ld_start) begin
         state_q     <= LOAD_LO;
         addr_q      <= '0;
         word_cnt_q  <= '0;
         ld_err_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         ld_ready_q  <= 1'b1;
      end else if (w_accept) begin
         case (state_q)
            LOAD_LO: begin
               if (ld_last) begin
                  // A lone low byte can never form a word: drop it
                  ld_err_q    <= 1'b1;
                  state_q     <= RUN;
                  cpu_reset_q <= 1'b0;
                  ld_ready_q  <= 1'b0;
               end else begin
                  lo_byte_q <= ld_data;
                  state_q   <= LOAD_HI;
               end
            end
            LOAD_HI: begin
               if (hi_byte_bad(ld_data)) begin
                  ld_err_q <= 1'b1;
               end
               addr_q     <= addr_q + 1'b1;
               word_cnt_q <= word_cnt_q + 1'b1;
               if (ld_last) begin
                  state_q     <= RUN;
                  cpu_reset_q <= 1'b0;
                  ld_ready_q  <= 1'b0;
               end else if (addr_q == LAST_ADDR) begin
                  // Memory full without an end marker
                  ld_err_q    <= 1'b1;
                  state_q     <= RUN;
                  cpu_reset_q <= 1'b0;
                  ld_ready_q  <= 1'b0;
               end else begin
                  state_q <= LOAD_LO;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   // Fetches outside the loaded program, or during loading, return a NOP
   assign Instr     = ((state_q == RUN) && w_pc_valid) ? w_rdata : INSTR_W'(NOP_INSTR);
   assign cpu_reset = cpu_reset_q;
   assign ld_ready  = ld_ready_q;
   assign ld_err    = ld_err_q;
   assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire
